opmem_responder: RTL
====================

Name: opmem_responder

Overview:
- Memory-side responder for the backend opload/opstore channels; the load/store stage is the initiator.
- Accepts word-indexed load and store requests over valid/ready and keeps one request in flight.
- After a fixed latency it performs the access to an internal 64-bit-word array and returns a one-cycle operation_done pulse, plus read data for loads.
- Serves as the data-memory model for simulation and as the template for the later dcache front end.

Parameters:
DEPTH_LOG2  12  log2 of array depth in 64-bit words
LATENCY     2   wait cycles between accept and access; legal range 1..15

Ports:
clock                   input   1   clock
reset_n                 input   1   asynchronous active-low reset
opload_index_valid      input   1   load request valid
opload_index_ready      output  1   load request accepted when valid & ready
opload_index            input   64  load word index (byte address >> 3)
opload_operation_done   output  1   one-cycle pulse, load complete
opload_read_data        output  64  full 64-bit word read
opstore_index_valid     input   1   store request valid
opstore_index_ready     output  1   store request accepted when valid & ready
opstore_index           input   64  store word index
opstore_write_data      input   64  store data, already lane-aligned
opstore_write_mask      input   64  bit-granular write enable
opstore_operation_done  output  1   one-cycle pulse, store complete
busy                    output  1   high whenever state != IDLE

Behaviour:
- Reset:
  - Reset is asynchronous, active-low (reset_n); clock is clock.
  - On reset: state=IDLE, both done=0, opload_read_data=0, busy=0, counter=0.
  - Array contents are not reset.
- States:
  - IDLE: ready outputs are live.
  - WAIT: counting down the latency.
  - DONE: completion pulse.
- Ready signals:
  - opload_index_ready = (state==IDLE).
  - opstore_index_ready = (state==IDLE) & ~opload_index_valid.
  - Loads win a simultaneous request. The losing store sees ready=0 and must hold its valid.
- IDLE, on a fire:
  - Latch kind, index[DEPTH_LOG2-1:0], write_data and write_mask.
  - Set counter=LATENCY-1 and go to WAIT.
  - Upper index bits are ignored, so indices alias modulo 2^DEPTH_LOG2.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==0, perform the access and go to DONE:
    - Store: array[idx] <= (array[idx] & ~mask) | (data & mask).
    - Load: opload_read_data <= array[idx].
  - Inputs are ignored in WAIT; valid asserted while not IDLE is not captured.
- DONE:
  - Exactly one of the done outputs is high, according to the latched kind; this is a registered output.
  - Next edge: return to IDLE. New requests can be accepted in the cycle after DONE.
- Timing: a fire in cycle T gives done high in cycle T+LATENCY+1. With LATENCY=2, a fire in cycle 0 gives done in cycle 3.
- Done never coincides with the fire cycle. The initiator's outstanding tracking depends on this.
- opload_read_data:
  - Holds its value until the next load access; store completions do not change it.
  - Lane extraction and sign extension are the initiator's job; the responder always returns the full word.
- Ordering: a load accepted after a store's done observes that store, including partial-mask merges.
- Reset mid-operation: the request is abandoned. A store not yet committed writes nothing, and no done is produced.
- A mask of all zeros is legal: the array is unchanged and done still pulses.

Test Plan:
- Reset, then release with no requests -> both readies=1; done=0, read_data=0, busy=0 in every cycle.
- Store index 5, data 0x1122334455667788, mask all-ones, fired in cycle 0 -> opstore_operation_done only in cycle 3, one cycle wide. Then load index 5+4096 (aliased) -> read_data=0x1122334455667788 with done exactly 3 cycles after the fire.
- After the previous case, store index 5, data 0xAB00, mask 0x000000000000FF00; then load index 5 -> 0x112233445566AB88.
- Load (index 7) and store (index 9) valid in the same IDLE cycle:
  - Load accepted; opstore_index_ready=0.
  - Store accepted in the cycle after the load's done.
  - Exactly one done per request, load first.
- Change opload_index and toggle valid during WAIT -> no capture, ready=0, a single done carrying the originally latched index's data.
- Store to index 3 (old value 0xFFFF) with LATENCY=2; assert reset_n=0 in cycle 1 -> no done. A subsequent load of index 3 returns 0xFFFF.

Source files
------------

// File: rtl/opmem_responder.sv
// Memory-side responder for the opload/opstore channels: one request in flight,
// fixed latency, access to an internal 64-bit word array, one-cycle done pulse.
module opmem_responder #(
    parameter int DEPTH_LOG2 = 12,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        opload_index_valid,
    output logic        opload_index_ready,
    input  logic [63:0] opload_index,
    output logic        opload_operation_done,
    output logic [63:0] opload_read_data,
    input  logic        opstore_index_valid,
    output logic        opstore_index_ready,
    input  logic [63:0] opstore_index,
    input  logic [63:0] opstore_write_data,
    input  logic [63:0] opstore_write_mask,
    output logic        opstore_operation_done,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t                  state;
    logic [3:0]              counter;
    logic                    kind_store;
    logic [DEPTH_LOG2-1:0]   idx;
    logic [63:0]             wdata;
    logic [63:0]             wmask;
    logic [63:0]             mem [2**DEPTH_LOG2];

    logic load_fire;
    logic store_fire;
    logic commit_store;
    logic unused_index_bits;

    function automatic logic [63:0] merge_word(input logic [63:0] old_word,
                                               input logic [63:0] data,
                                               input logic [63:0] mask);
        return (old_word & ~mask) | (data & mask);
    endfunction

    assign opload_index_ready  = (state == IDLE);
    assign opstore_index_ready = (state == IDLE) & ~opload_index_valid;
    assign busy                = (state != IDLE);

    assign load_fire    = opload_index_valid & opload_index_ready;
    assign store_fire   = opstore_index_valid & opstore_index_ready;
    // Derived from state, so an asynchronous reset in WAIT also cancels the write.
    assign commit_store = (state == WAIT) && (counter == 4'd0) && kind_store;

    // Upper index bits alias away; fold them so they are visibly consumed.
    assign unused_index_bits = ^{opload_index[63:DEPTH_LOG2], opstore_index[63:DEPTH_LOG2]};

    // Request capture and array write; data-only, never reset.
    always_ff @(posedge clock) begin
        if (load_fire || store_fire) begin
            kind_store <= store_fire;
            idx        <= load_fire ? opload_index[DEPTH_LOG2-1:0]
                                    : opstore_index[DEPTH_LOG2-1:0];
            wdata      <= opstore_write_data;
            wmask      <= opstore_write_mask;
        end
        if (commit_store) begin
            mem[idx] <= merge_word(mem[idx], wdata, wmask);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                  <= IDLE;
            counter                <= 4'd0;
            opload_operation_done  <= 1'b0;
            opstore_operation_done <= 1'b0;
            opload_read_data       <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    opload_operation_done  <= 1'b0;
                    opstore_operation_done <= 1'b0;
                    if (load_fire || store_fire) begin
                        counter <= 4'(LATENCY - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (counter == 4'd0) begin
                        if (kind_store) begin
                            opstore_operation_done <= 1'b1;
                        end else begin
                            opload_operation_done <= 1'b1;
                            opload_read_data      <= mem[idx];
                        end
                        state <= DONE;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                DONE: begin
                    opload_operation_done  <= 1'b0;
                    opstore_operation_done <= 1'b0;
                    state                  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
